// File: rtl/mem_arbiter.sv
// Two-to-one memory port arbiter: merges instruction-side and data-side (dtim) requests onto one external port.
// Latency: a request valid in IDLE at cycle t drives mem_in_valid at t+1; the response is forwarded combinationally.
// Backpressure: the granted request is held until mem_out_ready; an IDLE arbitration slot follows every transfer.
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   imem_in_* / imem_out_*            instruction-side request (valid, fence, instr, addr, wdata, wstrb) and response (rdata, ready)
//   dmem_in_* / dmem_out_*            data-side request/response, connected to dtim
//   mem_in_*  / mem_out_*             external memory request (registered) and response
// Build option: define MEM_ARBITER_RR_EN for round-robin tie breaking (prio register, dprio_init);
// otherwise the data port always wins ties.
module mem_arbiter #(
    parameter bit dprio_init = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_in_valid,
    input  logic        imem_in_fence,
    input  logic        imem_in_instr,
    input  logic [31:0] imem_in_addr,
    input  logic [31:0] imem_in_wdata,
    input  logic [3:0]  imem_in_wstrb,
    output logic [31:0] imem_out_rdata,
    output logic        imem_out_ready,

    input  logic        dmem_in_valid,
    input  logic        dmem_in_fence,
    input  logic        dmem_in_instr,
    input  logic [31:0] dmem_in_addr,
    input  logic [31:0] dmem_in_wdata,
    input  logic [3:0]  dmem_in_wstrb,
    output logic [31:0] dmem_out_rdata,
    output logic        dmem_out_ready,

    output logic        mem_in_valid,
    output logic        mem_in_fence,
    output logic        mem_in_instr,
    output logic [31:0] mem_in_addr,
    output logic [31:0] mem_in_wdata,
    output logic [3:0]  mem_in_wstrb,
    input  logic [31:0] mem_out_rdata,
    input  logic        mem_out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_i;
    logic   grant_d;
    logic   done;
    logic   pick_d;     // tie breaker: 1 = data port wins when both request

    // The requesters' instr bits are replaced by the grant side.
    logic unused_instr;
    assign unused_instr = imem_in_instr ^ dmem_in_instr;

`ifdef MEM_ARBITER_RR_EN
    logic prio;         // 1 = data port preferred on the next tie

    assign pick_d = prio;

    // After each completed transfer, point at the port that did not own it.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio <= dprio_init;
        end else if (done) begin
            prio <= (state == BUSY_I);
        end
    end
`else
    logic unused_dprio;
    assign unused_dprio = dprio_init;
    assign pick_d       = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (dmem_in_valid && (!imem_in_valid || pick_d)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (imem_in_valid) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_out_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request register: loaded on a grant, held through BUSY, cleared when the transfer completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_in_valid <= 1'b0;
            mem_in_fence <= 1'b0;
            mem_in_instr <= 1'b0;
            mem_in_addr  <= '0;
            mem_in_wdata <= '0;
            mem_in_wstrb <= '0;
        end else if (grant_d) begin
            mem_in_valid <= 1'b1;
            mem_in_fence <= dmem_in_fence;
            mem_in_instr <= 1'b0;
            mem_in_addr  <= dmem_in_addr;
            mem_in_wdata <= dmem_in_wdata;
            mem_in_wstrb <= dmem_in_wstrb;
        end else if (grant_i) begin
            mem_in_valid <= 1'b1;
            mem_in_fence <= imem_in_fence;
            mem_in_instr <= 1'b1;
            mem_in_addr  <= imem_in_addr;
            mem_in_wdata <= imem_in_wdata;
            mem_in_wstrb <= imem_in_wstrb;
        end else if (done) begin
            mem_in_valid <= 1'b0;
            mem_in_fence <= 1'b0;
            mem_in_instr <= 1'b0;
            mem_in_addr  <= '0;
            mem_in_wdata <= '0;
            mem_in_wstrb <= '0;
        end
    end

    // Responses go only to the owner; a reset in the ready cycle suppresses the handshake
    // because the transfer is being abandoned.
    assign imem_out_ready = (state == BUSY_I) && mem_out_ready && !reset;
    assign dmem_out_ready = (state == BUSY_D) && mem_out_ready && !reset;
    assign imem_out_rdata = imem_out_ready ? mem_out_rdata : '0;
    assign dmem_out_rdata = dmem_out_ready ? mem_out_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam bit DPRIO = 1'b1;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_in_valid, imem_in_fence, imem_in_instr;
    logic [31:0] imem_in_addr, imem_in_wdata;
    logic [3:0]  imem_in_wstrb;
    logic [31:0] imem_out_rdata;
    logic        imem_out_ready;
    logic        dmem_in_valid, dmem_in_fence, dmem_in_instr;
    logic [31:0] dmem_in_addr, dmem_in_wdata;
    logic [3:0]  dmem_in_wstrb;
    logic [31:0] dmem_out_rdata;
    logic        dmem_out_ready;
    logic        mem_in_valid, mem_in_fence, mem_in_instr;
    logic [31:0] mem_in_addr, mem_in_wdata;
    logic [3:0]  mem_in_wstrb;
    logic [31:0] mem_out_rdata;
    logic        mem_out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.dprio_init(DPRIO)) dut (
        .clock(clock), .reset(reset),
        .imem_in_valid(imem_in_valid), .imem_in_fence(imem_in_fence), .imem_in_instr(imem_in_instr),
        .imem_in_addr(imem_in_addr), .imem_in_wdata(imem_in_wdata), .imem_in_wstrb(imem_in_wstrb),
        .imem_out_rdata(imem_out_rdata), .imem_out_ready(imem_out_ready),
        .dmem_in_valid(dmem_in_valid), .dmem_in_fence(dmem_in_fence), .dmem_in_instr(dmem_in_instr),
        .dmem_in_addr(dmem_in_addr), .dmem_in_wdata(dmem_in_wdata), .dmem_in_wstrb(dmem_in_wstrb),
        .dmem_out_rdata(dmem_out_rdata), .dmem_out_ready(dmem_out_ready),
        .mem_in_valid(mem_in_valid), .mem_in_fence(mem_in_fence), .mem_in_instr(mem_in_instr),
        .mem_in_addr(mem_in_addr), .mem_in_wdata(mem_in_wdata), .mem_in_wstrb(mem_in_wstrb),
        .mem_out_rdata(mem_out_rdata), .mem_out_ready(mem_out_ready)
    );

    typedef struct {
        logic        iv;
        logic        ifence;
        logic [31:0] iaddr;
        logic        dv;
        logic        dfence;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        int          lat;        // busy cycles before the ready cycle
        logic [31:0] rdata;
        logic        exp_valid;
        logic        exp_instr;
        logic        exp_fence;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        imem_in_valid = 1'b0; imem_in_fence = 1'b0; imem_in_instr = 1'b0;
        imem_in_addr  = '0;   imem_in_wdata = '0;   imem_in_wstrb = '0;
        dmem_in_valid = 1'b0; dmem_in_fence = 1'b0; dmem_in_instr = 1'b0;
        dmem_in_addr  = '0;   dmem_in_wdata = '0;   dmem_in_wstrb = '0;
        mem_out_ready = 1'b0; mem_out_rdata = '0;
    endtask

    task automatic chk_mem_idle(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_in_valid), 32'd0);
        chk({tag, "_mem_addr"},  mem_in_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_in_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_in_wstrb), 32'd0);
        chk({tag, "_mem_instr_fence"}, 32'({mem_in_instr, mem_in_fence}), 32'd0);
    endtask

    // Apply one vector from IDLE: arbitration cycle, busy cycles, then a quiet IDLE cycle.
    task automatic apply_vec(input string tag, input vec_t v);
        logic own_rdy;
        imem_in_valid = v.iv; imem_in_fence = v.ifence; imem_in_addr = v.iaddr;
        imem_in_wdata = '0;   imem_in_wstrb = '0;       imem_in_instr = 1'($urandom);
        dmem_in_valid = v.dv; dmem_in_fence = v.dfence; dmem_in_addr = v.daddr;
        dmem_in_wdata = v.dwdata; dmem_in_wstrb = v.dwstrb; dmem_in_instr = 1'($urandom);
        mem_out_ready = !v.exp_valid;   // spurious ready when nothing is expected to be granted
        mem_out_rdata = v.rdata;
        @(negedge clock);
        chk({tag, "_idle_i_ready"}, 32'(imem_out_ready), 32'd0);
        chk({tag, "_idle_d_ready"}, 32'(dmem_out_ready), 32'd0);
        chk({tag, "_idle_i_rdata"}, imem_out_rdata, 32'd0);
        chk({tag, "_idle_d_rdata"}, dmem_out_rdata, 32'd0);
        chk({tag, "_idle_mem_valid"}, 32'(mem_in_valid), 32'd0);
        next_cycle();
        if (v.exp_valid) begin
            for (int k = 0; k <= v.lat; k++) begin
                own_rdy       = (k == v.lat);
                mem_out_ready = own_rdy;
                mem_out_rdata = v.rdata;
                // requester moves on in the ready cycle; the held request must not change
                if (own_rdy) begin
                    imem_in_addr = imem_in_addr + 32'd4;
                    dmem_in_addr = dmem_in_addr + 32'd4;
                end
                @(negedge clock);
                chk({tag, "_mem_valid"}, 32'(mem_in_valid), 32'd1);
                chk({tag, "_mem_addr"},  mem_in_addr, v.exp_addr);
                chk({tag, "_mem_wdata"}, mem_in_wdata, v.exp_wdata);
                chk({tag, "_mem_wstrb"}, 32'(mem_in_wstrb), 32'(v.exp_wstrb));
                chk({tag, "_mem_instr"}, 32'(mem_in_instr), 32'(v.exp_instr));
                chk({tag, "_mem_fence"}, 32'(mem_in_fence), 32'(v.exp_fence));
                chk({tag, "_i_ready"}, 32'(imem_out_ready), 32'(own_rdy && v.exp_instr));
                chk({tag, "_d_ready"}, 32'(dmem_out_ready), 32'(own_rdy && !v.exp_instr));
                chk({tag, "_i_rdata"}, imem_out_rdata, (own_rdy && v.exp_instr) ? v.rdata : 32'd0);
                chk({tag, "_d_rdata"}, dmem_out_rdata, (own_rdy && !v.exp_instr) ? v.rdata : 32'd0);
                next_cycle();
            end
        end
        drive_idle();
        @(negedge clock);
        chk_mem_idle({tag, "_after"});
        next_cycle();
    endtask

    // Reference model state for the random phase: one outstanding transfer record
    bit          m_busy;
    bit          m_own_d;
    bit          m_prio;
    int          m_lat;
    logic        m_fence;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    vec_t vt[7];
    vec_t vd;

    initial begin : main
        int  d_done;
        int  i_at;
        bit  i_done;
        bit  d_fin, i_fin;
        bit  exp_ir, exp_dr;

        vt[0] = '{1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0000_0013,
                  1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0};
        vt[1] = '{1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200, 32'h1111_2222, 4'h3, 1, 32'hAAAA_0001,
                  1'b1, 1'b0, 1'b0, 32'h200, 32'h1111_2222, 4'h3};
        vt[2] = '{1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200, 32'h1111_2222, 4'h3, 1, 32'hBBBB_0002,
                  1'b1, RR, 1'b0, RR ? 32'h100 : 32'h200, RR ? 32'h0 : 32'h1111_2222, RR ? 4'h0 : 4'h3};
        vt[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0000_0055,
                  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vt[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'hDEAD_BEEF, 4'hF, 2, 32'h0,
                  1'b1, 1'b0, 1'b0, 32'h1000, 32'hDEAD_BEEF, 4'hF};
        vt[5] = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0,
                  1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 4'h0};
        vt[6] = '{1'b1, 1'b0, 32'h300, 1'b1, 1'b1, 32'h400, 32'h5, 4'h1, 0, 32'h00C0_FFEE,
                  1'b1, 1'b0, 1'b1, 32'h400, 32'h5, 4'h1};
        vd    = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 0, 32'h1234_5678,
                  1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 4'h0};

        // Reset state
        reset = 1'b1;
        drive_idle();
        mem_out_ready = 1'b1;
        mem_out_rdata = 32'h55;
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk_mem_idle("reset");
        chk("reset_i_ready", 32'(imem_out_ready), 32'd0);
        chk("reset_d_ready", 32'(dmem_out_ready), 32'd0);
        chk("reset_d_rdata", dmem_out_rdata, 32'd0);
        next_cycle();
        reset = 1'b0;
        drive_idle();

        for (int i = 0; i < 7; i++) apply_vec($sformatf("vec%0d", i), vt[i]);

        // Reset in the second BUSY_D cycle with memory ready at the same time
        apply_vec("pre_rst", vd);
        dmem_in_valid = 1'b1; dmem_in_addr = 32'h800; dmem_in_wdata = 32'h77; dmem_in_wstrb = 4'h2;
        next_cycle();
        @(negedge clock);
        chk("rst_busy_valid", 32'(mem_in_valid), 32'd1);
        next_cycle();
        reset = 1'b1;
        mem_out_ready = 1'b1;
        mem_out_rdata = 32'h99;
        @(negedge clock);
        chk("rst_d_ready", 32'(dmem_out_ready), 32'd0);
        chk("rst_d_rdata", dmem_out_rdata, 32'd0);
        chk("rst_i_ready", 32'(imem_out_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive_idle();
        @(negedge clock);
        chk_mem_idle("rst_after");
        chk("rst_after_d_ready", 32'(dmem_out_ready), 32'd0);
        next_cycle();
        apply_vec("post_rst_tie", vt[1]);   // prio must be back at the data port

        // Back-to-back data requests with the instruction port waiting
        d_done = 0; i_at = -1; i_done = 1'b0;
        dmem_in_valid = 1'b1; dmem_in_addr = 32'h600;
        for (int cyc = 0; cyc < 60 && !(d_done == 3 && i_done); cyc++) begin
            if (cyc == 1) begin
                imem_in_valid = 1'b1;
                imem_in_addr  = 32'h500;
            end
            mem_out_ready = mem_in_valid;
            mem_out_rdata = 32'(cyc);
            @(negedge clock);
            d_fin = dmem_out_ready;
            i_fin = imem_out_ready;
            if (d_fin) d_done++;
            if (i_fin) begin
                i_done = 1'b1;
                i_at   = d_done;
            end
            next_cycle();
            if (d_fin) begin
                dmem_in_addr = dmem_in_addr + 32'd4;
                if (d_done == 3) dmem_in_valid = 1'b0;
            end
            if (i_fin) imem_in_valid = 1'b0;
        end
        chk("burst_d_served", 32'(d_done), 32'd3);
        chk("burst_i_served", 32'(i_done), 32'd1);
        chk("burst_i_after_d", 32'(i_at), RR ? 32'd1 : 32'd3);
        drive_idle();
        next_cycle();

        // Randomized traffic against the transaction-level model
        reset = 1'b1;
        next_cycle();
        reset   = 1'b0;
        m_busy  = 1'b0;
        m_prio  = DPRIO;
        m_own_d = 1'b0;
        m_lat   = 0;
        m_fence = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom % 97) == 0;
            mem_out_ready = m_busy ? (m_lat == 0) : (($urandom % 4) == 0);
            mem_out_rdata = $urandom;
            imem_in_instr = 1'($urandom);
            dmem_in_instr = 1'($urandom);
            if (m_busy && mem_out_ready && 1'($urandom)) begin
                if (m_own_d) begin
                    dmem_in_addr = $urandom; dmem_in_wdata = $urandom;
                    dmem_in_wstrb = 4'($urandom); dmem_in_fence = 1'($urandom);
                end else begin
                    imem_in_addr = $urandom; imem_in_fence = 1'($urandom);
                end
            end
            if (!imem_in_valid && ($urandom % 3) == 0) begin
                imem_in_valid = 1'b1; imem_in_addr = $urandom; imem_in_fence = 1'(($urandom % 8) == 0);
                imem_in_wdata = $urandom; imem_in_wstrb = 4'($urandom);
            end
            if (!dmem_in_valid && ($urandom % 3) == 0) begin
                dmem_in_valid = 1'b1; dmem_in_addr = $urandom; dmem_in_fence = 1'(($urandom % 8) == 0);
                dmem_in_wdata = $urandom; dmem_in_wstrb = 4'($urandom);
            end
            @(negedge clock);
            exp_ir = m_busy && !m_own_d && mem_out_ready && !reset;
            exp_dr = m_busy &&  m_own_d && mem_out_ready && !reset;
            chk("rnd_i_ready", 32'(imem_out_ready), 32'(exp_ir));
            chk("rnd_d_ready", 32'(dmem_out_ready), 32'(exp_dr));
            chk("rnd_i_rdata", imem_out_rdata, exp_ir ? mem_out_rdata : 32'd0);
            chk("rnd_d_rdata", dmem_out_rdata, exp_dr ? mem_out_rdata : 32'd0);
            chk("rnd_mem_valid", 32'(mem_in_valid), 32'(m_busy));
            chk("rnd_mem_addr", mem_in_addr, m_busy ? m_addr : 32'd0);
            chk("rnd_mem_wdata", mem_in_wdata, m_busy ? m_wdata : 32'd0);
            chk("rnd_mem_wstrb", 32'(mem_in_wstrb), m_busy ? 32'(m_wstrb) : 32'd0);
            chk("rnd_mem_instr", 32'(mem_in_instr), 32'(m_busy && !m_own_d));
            chk("rnd_mem_fence", 32'(mem_in_fence), 32'(m_busy && m_fence));
            d_fin = 1'b0;
            i_fin = 1'b0;
            if (reset) begin
                m_busy = 1'b0;
                m_prio = DPRIO;
            end else if (!m_busy) begin
                if (imem_in_valid || dmem_in_valid) begin
                    // a lone requester wins; a tie goes to the preferred port
                    m_own_d = dmem_in_valid && (!imem_in_valid || (RR ? m_prio : 1'b1));
                    m_busy  = 1'b1;
                    m_lat   = $urandom % 4;
                    if (m_own_d) begin
                        m_addr = dmem_in_addr; m_wdata = dmem_in_wdata;
                        m_wstrb = dmem_in_wstrb; m_fence = dmem_in_fence;
                    end else begin
                        m_addr = imem_in_addr; m_wdata = imem_in_wdata;
                        m_wstrb = imem_in_wstrb; m_fence = imem_in_fence;
                    end
                end
            end else if (mem_out_ready) begin
                m_busy = 1'b0;
                m_prio = !m_own_d;
                d_fin  = m_own_d;
                i_fin  = !m_own_d;
            end else begin
                m_lat--;
            end
            next_cycle();
            if (d_fin) dmem_in_valid = 1'($urandom);
            if (i_fin) imem_in_valid = 1'($urandom);
        end

        reset = 1'b0;
        drive_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

endmodule
